// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared types, display constants and match helpers for slot_judge
// Purpose: state and result encodings, 7-segment patterns, match classification.
// Ports: none (package).
package slot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPIN    = 3'd1,
    EVAL    = 3'd2,
    PAYOUT  = 3'd3,
    RELEASE = 3'd4,
    OVER    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    PAIR   = 2'd1,
    TRIPLE = 2'd2
  } result_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_E     = 8'h79;

  // Digits are zero-extended to this width before comparison, so any
  // reel width up to 16 bits compares on its raw value.
  localparam int DIGIT_W_MAX = 16;

  function automatic result_t classify(input logic [DIGIT_W_MAX-1:0] a,
                                       input logic [DIGIT_W_MAX-1:0] b,
                                       input logic [DIGIT_W_MAX-1:0] c);
    result_t r;
    if (a == b && b == c)
      r = TRIPLE;
    else if (a == b || b == c || a == c)
      r = PAIR;
    else
      r = NONE;
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input result_t r);
    logic [7:0] s;
    case (r)
      PAIR:    s = SEG_2;
      TRIPLE:  s = SEG_3;
      default: s = SEG_0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/slot_judge_rise_detect.sv
// rtl/slot_judge_rise_detect.sv - level to one-cycle rising-edge pulse
// Purpose: registers a level input and flags the cycle in which it goes 0->1.
// Ports: clk (clock), reset (async active-low), level (input level),
//        pulse (high for the single cycle where level=1 and its registered copy=0).
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      level_q <= 1'b0;
    else
      level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/slot_judge.sv
// rtl/slot_judge.sv - slot-machine round evaluation, credit keeping and display
// Purpose: one game round per start edge: charge bet, wait for all reels locked,
//          classify digits, pay prize with saturation, blink on win, show result.
// Ports: clk_2 (clock), reset (async active-low), start (round request level),
//        digit1..3 (reel values), lock1..3 (reel stopped),
//        credits (balance), LED ([2:0] state, [6] game over, [7] win blink),
//        SEG (7-segment a..g in bits 0..6, dp=0).
module slot_judge
  import slot_pkg::*;
#(
  parameter int NBITS_COUNT  = 4,
  parameter int NBITS_CREDIT = 8,
  parameter int CREDIT_INIT  = 10,
  parameter int CREDIT_MAX   = 99,
  parameter int BET          = 1,
  parameter int PRIZE_PAIR   = 2,
  parameter int PRIZE_TRIPLE = 10,
  parameter int BLINK_CYCLES = 4
) (
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NBITS_COUNT-1:0]  digit1,
  input  logic [NBITS_COUNT-1:0]  digit2,
  input  logic [NBITS_COUNT-1:0]  digit3,
  input  logic                    lock1,
  input  logic                    lock2,
  input  logic                    lock3,
  output logic [NBITS_CREDIT-1:0] credits,
  output logic [7:0]              LED,
  output logic [7:0]              SEG
);

  localparam logic [NBITS_CREDIT-1:0] CREDIT_INIT_C  = NBITS_CREDIT'(CREDIT_INIT);
  localparam logic [NBITS_CREDIT-1:0] CREDIT_MAX_C   = NBITS_CREDIT'(CREDIT_MAX);
  localparam logic [NBITS_CREDIT-1:0] BET_C          = NBITS_CREDIT'(BET);
  localparam logic [NBITS_CREDIT-1:0] PRIZE_PAIR_C   = NBITS_CREDIT'(PRIZE_PAIR);
  localparam logic [NBITS_CREDIT-1:0] PRIZE_TRIPLE_C = NBITS_CREDIT'(PRIZE_TRIPLE);
  localparam int                      CW             = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0]           CNT_LAST       = CW'(BLINK_CYCLES - 1);

  state_t                  state, state_n;
  logic [NBITS_CREDIT-1:0] credits_n;
  logic [NBITS_COUNT-1:0]  d1_q, d2_q, d3_q;
  logic                    capture;
  result_t                 cls, result_q, result_n;
  logic                    result_valid_q, result_valid_n;
  logic                    blink_q, blink_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [NBITS_CREDIT-1:0] prize;
  logic [NBITS_CREDIT:0]   sum;
  logic                    start_edge;

  rise_detect u_start_edge (
    .clk   (clk_2),
    .reset (reset),
    .level (start),
    .pulse (start_edge)
  );

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n        = state;
    credits_n      = credits;
    capture        = 1'b0;
    result_n       = result_q;
    result_valid_n = result_valid_q;
    blink_n        = 1'b0;
    cnt_n          = cnt_q;

    cls = classify(DIGIT_W_MAX'(d1_q), DIGIT_W_MAX'(d2_q), DIGIT_W_MAX'(d3_q));
    case (cls)
      PAIR:    prize = PRIZE_PAIR_C;
      TRIPLE:  prize = PRIZE_TRIPLE_C;
      default: prize = '0;
    endcase
    sum = {1'b0, credits} + {1'b0, prize};

    case (state)
      IDLE: begin
        if (start_edge) begin
          if (credits >= BET_C) begin
            state_n   = SPIN;
            credits_n = credits - BET_C;
          end else begin
            state_n = OVER;
          end
        end
      end
      SPIN: begin
        if (lock1 && lock2 && lock3) begin
          capture = 1'b1;
          state_n = EVAL;
        end
      end
      EVAL: begin
        state_n        = PAYOUT;
        credits_n      = (sum > {1'b0, CREDIT_MAX_C}) ? CREDIT_MAX_C : sum[NBITS_CREDIT-1:0];
        result_n       = cls;
        result_valid_n = 1'b1;
        blink_n        = (cls != NONE);
        cnt_n          = '0;
      end
      PAYOUT: begin
        if (cnt_q == CNT_LAST) begin
          state_n = RELEASE;
        end else begin
          cnt_n   = cnt_q + 1'b1;
          blink_n = (result_q != NONE) && !blink_q;
        end
      end
      RELEASE: begin
        // Player must let go of start and all reels before a new round can arm.
        if (!start && !lock1 && !lock2 && !lock3)
          state_n = IDLE;
      end
      OVER: ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      credits        <= CREDIT_INIT_C;
      d1_q           <= '0;
      d2_q           <= '0;
      d3_q           <= '0;
      result_q       <= NONE;
      result_valid_q <= 1'b0;
      blink_q        <= 1'b0;
      cnt_q          <= '0;
    end else begin
      credits        <= credits_n;
      result_q       <= result_n;
      result_valid_q <= result_valid_n;
      blink_q        <= blink_n;
      cnt_q          <= cnt_n;
      if (capture) begin
        d1_q <= digit1;
        d2_q <= digit2;
        d3_q <= digit3;
      end
    end
  end

  // Both displays decode registered state only.
  assign LED = {blink_q, (state == OVER), 3'b000, state};
  assign SEG = (state == OVER) ? SEG_E :
               result_valid_q  ? seg_of(result_q) : SEG_BLANK;

endmodule

// File: doc/slot_judge.md
# slot_judge

Result-evaluation stage of the slot-machine design, placed directly downstream of the three-reel counter block. It consumes the three reel digits and their lock switches, runs one game round per start request, charges a bet, detects pair/triple matches, keeps a saturating credit balance and drives the LED and 7-segment outputs with the round result.

## Interface
- NBITS_COUNT, 4: width of each reel digit
- NBITS_CREDIT, 8: credit register width
- CREDIT_INIT, 10: credits after reset
- CREDIT_MAX, 99: saturation ceiling
- BET, 1: cost per round
- PRIZE_PAIR, 2: credits added when exactly two digits are equal
- PRIZE_TRIPLE, 10: credits added when all three digits are equal
- BLINK_CYCLES, 4: length of the PAYOUT state in cycles

- clk_2  in  1  single system clock; all state on its rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces the reset values immediately
- start  in  1  round request switch, level; only a rising edge acts
- digit1, digit2, digit3  in  NBITS_COUNT each  reel values from the counter stage
- lock1, lock2, lock3  in  1 each  reel lock switches (1 = reel stopped)
- credits  out  NBITS_CREDIT  current balance
- LED  out  8  status: [2:0] state code, [6] game over, [7] win blink
- SEG  out  8  7-segment pattern, bit0=a … bit6=g, bit7=dp (always 0)

## Operation
- Reset values: state IDLE, credits = CREDIT_INIT, LED = 0, SEG = SEG_BLANK (0x00), captured digits = 0, start_q = 0.
- Rising edge: start_edge = start & ~start_q; start_q registered every cycle.
- States (LED[2:0] code): IDLE 0, SPIN 1, EVAL 2, PAYOUT 3, RELEASE 4, OVER 5.
- IDLE: on start_edge, if credits ≥ BET → SPIN, credits -= BET; else → OVER. No other exit.
- SPIN: waits until lock1 & lock2 & lock3 are all 1 in the same cycle; in that cycle the three digits are captured and state → EVAL. Partial locks/unlocks are ignored. start_edge ignored.
- EVAL (1 cycle): class = TRIPLE if d1==d2==d3; PAIR if exactly one pair equal; else NONE. Comparison on raw NBITS_COUNT values. → PAYOUT; credits += prize (0/PRIZE_PAIR/PRIZE_TRIPLE), saturating at CREDIT_MAX.
- PAYOUT: BLINK_CYCLES cycles; LED[7] toggles every cycle starting at 1 if class ≠ NONE, else stays 0. Then → RELEASE.
- RELEASE: waits for start = 0 and all locks = 0 (same cycle) → IDLE. Prevents an immediate re-spin.
- OVER: LED[6] = 1, SEG = SEG_E (0x79). Left only by reset.
- SEG outside OVER: last result, NONE → SEG_0 (0x3F), PAIR → SEG_2 (0x5B), TRIPLE → SEG_3 (0x4F); blank until the first EVAL.
- Saturation: credits never exceed CREDIT_MAX; sums computed one bit wider.

## Timing
- start rising at sample n → state SPIN and decremented credits visible at n+1.
- All locks at sample m → EVAL at m+1 → PAYOUT, updated credits and SEG at m+2.
- PAYOUT occupies exactly BLINK_CYCLES cycles; RELEASE entered at m+2+BLINK_CYCLES.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset assertion mid-round aborts immediately; no bet refund.

## Structure
- Package slot_pkg: state_t enum (codes above), result_t enum {NONE, PAIR, TRIPLE}, SEG_* constants.
- One sub-module: rise_detect (registered level → one-cycle pulse, async active-low reset), used for start.
- Match classification as a function in slot_pkg.

## Test plan
- Reset then start pulse → credits 10→9 at next cycle, LED[2:0]=1.
- SPIN, digits 5/5/5, all locks → two cycles later credits 9→19, SEG=0x4F, LED[7] toggles 1,0,1,0.
- Digits 2/4/2 → credits +2, SEG=0x5B; digits 1/2/3 → credits unchanged, SEG=0x3F, LED[7]=0.
- Credits at 95, triple → credits 99 (saturated).
- Credits 0, start edge → OVER, SEG=0x79, LED[6]=1; further starts ignored until reset.
- start held high through PAYOUT → stays in RELEASE; no second round until start=0 and locks=0; reset in SPIN → credits 10, IDLE.
